// File: rtl/det_pkg.sv
// Shared state type, default width and saturating helper for det_packet_stats.
package det_pkg;

  localparam int DET_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    EMIT  = 2'd2
  } stats_state_t;

  // Increment that sticks at max instead of wrapping; callers zero-extend to 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max);
    if (value >= max) begin
      return max;
    end else begin
      return value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/det_sat_counter.sv
// Saturating counter with synchronous load; load wins over increment.
module det_sat_counter
  import det_pkg::*;
#(
  parameter int CNT_W = DET_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_value
);

  logic [CNT_W-1:0] r_value;
  logic [CNT_W-1:0] w_max;

  assign w_max = {CNT_W{1'b1}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_inc) begin
      r_value <= CNT_W'(sat_inc(32'(r_value), 32'(w_max)));
    end else begin
      r_value <= r_value;
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/det_packet_stats.sv
// Per-packet length / ones / longest-run statistics with a valid/ready result record.
// Longest-run tracking is built only when DET_STATS_MAXRUN_EN is defined.
module det_packet_stats
  import det_pkg::*;
#(
  parameter int CNT_W = DET_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic             i_sop,
  input  logic             i_eop,
  input  logic             inp,
  output logic             i_ready,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [CNT_W-1:0] o_len,
  output logic [CNT_W-1:0] o_ones,
  output logic [CNT_W-1:0] o_maxrun,
  output logic             o_abort
);

  stats_state_t     r_state;
  stats_state_t     w_state_next;
  logic             w_ready;
  logic             w_valid;
  logic             w_accept;
  logic             w_start;
  logic             w_step;
  logic             r_abort;
  logic [CNT_W-1:0] w_inp_ext;
  logic [CNT_W-1:0] w_len;
  logic [CNT_W-1:0] w_ones;

  assign w_inp_ext = {{(CNT_W-1){1'b0}}, inp};
  assign w_accept  = i_valid && w_ready;
  assign w_start   = w_accept && i_sop;
  assign w_step    = w_accept && !i_sop && (r_state == COUNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && i_sop) begin
          w_state_next = i_eop ? EMIT : COUNT;
        end else begin
          w_state_next = IDLE;
        end
      end
      COUNT: begin
        if (w_accept && i_eop) begin
          w_state_next = EMIT;
        end else begin
          w_state_next = COUNT;
        end
      end
      EMIT: begin
        if (o_ready) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = EMIT;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Ready and valid come from the state register only, never from an input.
  always_comb begin
    w_ready = 1'b1;
    w_valid = 1'b0;
    case (r_state)
      IDLE:    begin w_ready = 1'b1; w_valid = 1'b0; end
      COUNT:   begin w_ready = 1'b1; w_valid = 1'b0; end
      EMIT:    begin w_ready = 1'b0; w_valid = 1'b1; end
      default: begin w_ready = 1'b1; w_valid = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_abort <= 1'b0;
    end else if ((r_state == EMIT) && o_ready) begin
      r_abort <= 1'b0;
    end else if ((r_state == COUNT) && w_start) begin
      r_abort <= 1'b1;
    end else begin
      r_abort <= r_abort;
    end
  end

  det_sat_counter #(.CNT_W(CNT_W)) u_len (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_start),
    .i_load_val ({{(CNT_W-1){1'b0}}, 1'b1}),
    .i_inc      (w_step),
    .o_value    (w_len)
  );

  det_sat_counter #(.CNT_W(CNT_W)) u_ones (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_start),
    .i_load_val (w_inp_ext),
    .i_inc      (w_step && inp),
    .o_value    (w_ones)
  );

`ifdef DET_STATS_MAXRUN_EN
  logic [CNT_W-1:0] w_run;
  logic [CNT_W-1:0] w_run_inc;
  logic [CNT_W-1:0] r_maxrun;

  // A 0 beat reloads the run with 0 (w_inp_ext is zero then).
  det_sat_counter #(.CNT_W(CNT_W)) u_run (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_start || (w_step && !inp)),
    .i_load_val (w_inp_ext),
    .i_inc      (w_step && inp),
    .o_value    (w_run)
  );

  assign w_run_inc = CNT_W'(sat_inc(32'(w_run), 32'({CNT_W{1'b1}})));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_maxrun <= {CNT_W{1'b0}};
    end else if (w_start) begin
      r_maxrun <= w_inp_ext;
    end else if (w_step && inp && (w_run_inc > r_maxrun)) begin
      r_maxrun <= w_run_inc;
    end else begin
      r_maxrun <= r_maxrun;
    end
  end

  assign o_maxrun = r_maxrun;
`else
  assign o_maxrun = {CNT_W{1'b0}};
`endif

  assign i_ready = w_ready;
  assign o_valid = w_valid;
  assign o_len   = w_len;
  assign o_ones  = w_ones;
  assign o_abort = r_abort;

endmodule

// File: tb/tb_det_packet_stats.sv
// Bench for det_packet_stats: packet table, hand-written corner sequences and a model-fed scoreboard.
module tb_det_packet_stats;

`ifdef DET_STATS_MAXRUN_EN
  localparam bit MR_EN = 1'b1;
`else
  localparam bit MR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_valid = 1'b0;
  logic       i_sop = 1'b0;
  logic       i_eop = 1'b0;
  logic       inp = 1'b0;
  logic       o_ready = 1'b1;
  logic       i_ready, o_valid, o_abort;
  logic [7:0] o_len, o_ones, o_maxrun;
  logic       i_ready4, o_valid4, o_abort4;
  logic [3:0] o4_len, o4_ones, o4_maxrun;

  int n_pass = 0;
  int n_total = 0;

  typedef struct { int len; int ones; int mx; int ab; } rec_t;
  rec_t q[$];

  typedef struct { int n; logic [31:0] bits; int e_len; int e_ones; int e_max; } vec_t;
  vec_t tbl[5];

  det_packet_stats #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_sop(i_sop), .i_eop(i_eop), .inp(inp),
    .i_ready(i_ready), .o_valid(o_valid), .o_ready(o_ready), .o_len(o_len), .o_ones(o_ones),
    .o_maxrun(o_maxrun), .o_abort(o_abort)
  );

  det_packet_stats #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_sop(i_sop), .i_eop(i_eop), .inp(inp),
    .i_ready(i_ready4), .o_valid(o_valid4), .o_ready(o_ready), .o_len(o4_len), .o_ones(o4_ones),
    .o_maxrun(o4_maxrun), .o_abort(o_abort4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int mr(input int x);
    return MR_EN ? x : 0;
  endfunction

  function automatic int sat(input int x, input int m);
    return (x > m) ? m : x;
  endfunction

  task automatic beat(input logic s, input logic e, input logic b);
    i_valid = 1'b1; i_sop = s; i_eop = e; inp = b;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0; inp = 1'b0;
    @(posedge clk); #1;
  endtask

  // Reference model: raw (unsaturated) statistics, pushes one record per accepted eop.
  initial begin
    int m_st, m_len, m_ones, m_run, m_max, m_ab;
    bit take;
    m_st = 0; m_len = 0; m_ones = 0; m_run = 0; m_max = 0; m_ab = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_st = 0; m_ab = 0;
        q.delete();
      end else if (m_st == 2) begin
        if (o_ready) m_st = 0;
      end else if (i_valid) begin
        take = 1'b1;
        if (i_sop) begin
          m_ab = (m_st == 1) ? 1 : 0;
          m_len = 1; m_ones = int'(inp); m_run = int'(inp); m_max = int'(inp); m_st = 1;
        end else if (m_st == 1) begin
          m_len = m_len + 1;
          m_ones = m_ones + int'(inp);
          m_run = inp ? m_run + 1 : 0;
          if (m_run > m_max) m_max = m_run;
        end else begin
          take = 1'b0;
        end
        if (take && i_eop) begin
          q.push_back('{m_len, m_ones, m_max, m_ab});
          m_st = 2;
        end
      end
    end
  end

  // Scoreboard: compare each record on the cycle it is handed over.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (!reset && o_valid && o_ready) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected: got a record, expected none (len=%0d)", o_len);
        end else begin
          r = q.pop_front();
          chk("sb_len", int'(o_len), sat(r.len, 255));
          chk("sb_ones", int'(o_ones), sat(r.ones, 255));
          chk("sb_maxrun", int'(o_maxrun), mr(sat(r.mx, 255)));
          chk("sb_abort", int'(o_abort), r.ab);
          chk("sb4_valid", int'(o_valid4), 1);
          chk("sb4_len", int'(o4_len), sat(r.len, 15));
          chk("sb4_ones", int'(o4_ones), sat(r.ones, 15));
          chk("sb4_maxrun", int'(o4_maxrun), mr(sat(r.mx, 15)));
          chk("sb4_abort", int'(o_abort4), r.ab);
        end
      end
    end
  end

  initial begin
    tbl[0] = '{5, 32'h0000_001B, 5, 4, 2};
    tbl[1] = '{1, 32'h0000_0001, 1, 1, 1};
    tbl[2] = '{4, 32'h0000_0000, 4, 0, 0};
    tbl[3] = '{8, 32'h0000_005D, 8, 5, 3};
    tbl[4] = '{3, 32'h0000_0006, 3, 2, 2};

    #1;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_ready", int'(i_ready), 1);
    chk("rst_ready4", int'(i_ready4), 1);
    chk("rst_len", int'(o_len), 0);
    chk("rst_ones", int'(o_ones), 0);
    chk("rst_maxrun", int'(o_maxrun), 0);
    chk("rst_abort", int'(o_abort), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    idle_cycle();

    // Table: single packets with the sink always ready.
    for (int t = 0; t < 5; t++) begin
      for (int j = 0; j < tbl[t].n; j++) begin
        beat(j == 0, j == tbl[t].n - 1, tbl[t].bits[j]);
      end
      chk("tbl_valid", int'(o_valid), 1);
      chk("tbl_ready_low", int'(i_ready), 0);
      chk("tbl_len", int'(o_len), tbl[t].e_len);
      chk("tbl_ones", int'(o_ones), tbl[t].e_ones);
      chk("tbl_maxrun", int'(o_maxrun), mr(tbl[t].e_max));
      chk("tbl_abort", int'(o_abort), 0);
      idle_cycle();
      chk("tbl_valid_1cyc", int'(o_valid), 0);
      chk("tbl_ready_back", int'(i_ready), 1);
    end

    // Back-to-back: held sop is refused during EMIT, accepted the cycle after.
    beat(1'b1, 1'b1, 1'b1);
    chk("b2b_ready_low", int'(i_ready), 0);
    beat(1'b1, 1'b0, 1'b0);
    chk("b2b_taken", int'(o_valid), 0);
    chk("b2b_ready", int'(i_ready), 1);
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b1);
    chk("b2b_len", int'(o_len), 2);
    chk("b2b_ones", int'(o_ones), 1);
    chk("b2b_abort", int'(o_abort), 0);
    idle_cycle();

    // Back-pressure for 10 cycles with junk beats offered upstream.
    o_ready = 1'b0;
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      i_valid = 1'b1;
      i_sop = 1'($urandom_range(1, 0));
      i_eop = 1'($urandom_range(1, 0));
      inp = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
      chk("bp_valid", int'(o_valid), 1);
      chk("bp_ready_low", int'(i_ready), 0);
      chk("bp_len", int'(o_len), 3);
      chk("bp_ones", int'(o_ones), 2);
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", int'(o_valid), 0);
    chk("bp_ready_back", int'(i_ready), 1);

    // Early sop restarts the counters and flags the record.
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b0, 1'b0, 1'b1);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b0, 1'b1, 1'b1);
    chk("ab_len", int'(o_len), 2);
    chk("ab_ones", int'(o_ones), 2);
    chk("ab_maxrun", int'(o_maxrun), mr(2));
    chk("ab_abort", int'(o_abort), 1);
    idle_cycle();
    chk("ab_cleared", int'(o_abort), 0);

    // Saturation: 20 ones into the 4-bit instance.
    for (int j = 0; j < 20; j++) begin
      beat(j == 0, j == 19, 1'b1);
    end
    chk("sat4_len", int'(o4_len), 15);
    chk("sat4_ones", int'(o4_ones), 15);
    chk("sat4_maxrun", int'(o4_maxrun), mr(15));
    chk("sat8_len", int'(o_len), 20);
    chk("sat8_maxrun", int'(o_maxrun), mr(20));
    idle_cycle();

    // Asynchronous reset mid-packet.
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b0, 1'b0, 1'b1);
    i_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rmid_valid", int'(o_valid), 0);
    chk("rmid_ready", int'(i_ready), 1);
    chk("rmid_len", int'(o_len), 0);
    #2;
    reset = 1'b0;
    idle_cycle();

    // Asynchronous reset while a record is pending.
    o_ready = 1'b0;
    beat(1'b1, 1'b1, 1'b1);
    chk("remit_pending", int'(o_valid), 1);
    i_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("remit_valid", int'(o_valid), 0);
    chk("remit_ready", int'(i_ready), 1);
    #2;
    reset = 1'b0;
    o_ready = 1'b1;
    idle_cycle();
    idle_cycle();
    chk("remit_no_record", int'(o_valid), 0);

    // Clean packet after reset.
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b1);
    chk("post_len", int'(o_len), 2);
    chk("post_ones", int'(o_ones), 1);
    chk("post_abort", int'(o_abort), 0);
    idle_cycle();
    idle_cycle();
    chk("sb_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/det_packet_stats.md
# det_packet_stats

Downstream consumer of the bit-detector output stream. It accepts the detector's beat stream (valid, sop, eop, detected bit) and, for each packet, accumulates the packet length and the number of detected 1 bits. When the packet ends, it presents one result record on a valid/ready handshake, back-pressuring the detector until that record is taken. It sits between the bit detector and the board LED/status logic.

## Interface
Parameters:
- CNT_W, 8, width of every counter and result field.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  upstream beat valid.
- i_sop  in  1  start of packet, qualified by i_valid.
- i_eop  in  1  end of packet, qualified by i_valid.
- inp  in  1  detected bit from the bit detector.
- i_ready  out  1  this block can accept a beat; driven to the detector's o_ready.
- o_valid  out  1  result record valid.
- o_ready  in  1  downstream accepts the record.
- o_len  out  CNT_W  beats in the packet, saturating.
- o_ones  out  CNT_W  beats with inp=1, saturating.
- o_maxrun  out  CNT_W  longest run of consecutive inp=1 beats (see Configuration).
- o_abort  out  1  this record follows a packet that was restarted by an early sop.

## Operation
- Beat accepted: i_valid && i_ready.
- States:
  - IDLE
  - COUNT
  - EMIT
- IDLE:
  - Accepted beat with i_sop: len=1, ones=inp, run=inp, maxrun=inp.
  - If i_eop is also set on that beat, go to EMIT; otherwise go to COUNT.
  - Accepted beats without i_sop are discarded.
- COUNT:
  - Each accepted beat: len+1; ones+inp; run=inp ? run+1 : 0; maxrun=max(maxrun, new run).
  - Accepted beat with i_eop: include the beat, then go to EMIT.
  - Accepted beat with i_sop, without i_eop: restart the counters from this beat and set the internal abort flag. Stay in COUNT.
  - Accepted beat with both i_sop and i_eop: restart the counters from this beat, set the abort flag, then go to EMIT.
- EMIT:
  - o_valid=1; o_len/o_ones/o_maxrun/o_abort hold the latched values.
  - On o_ready: go to IDLE and clear the abort flag.
- i_ready = (state != EMIT). It is decoded from the state register only, with no combinational path from any input.
- All counters saturate at 2^CNT_W-1. There is no wrap-around.
- Result fields are stable while o_valid=1 and o_ready=0.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE.
  - o_valid=0; o_len, o_ones, o_maxrun, o_abort = 0.
  - All counters = 0.
  - i_ready=1 one delta after reset asserts.
- Latency: if the eop beat is accepted at edge k, o_valid=1 from edge k to edge k+1; i_ready=0 over the same interval.
- Record taken at edge m (o_valid && o_ready): o_valid=0 and i_ready=1 after edge m. The next sop can be accepted at edge m+1.
- Minimum turnaround: one idle cycle per packet (the EMIT cycle), even with o_ready held at 1.
- Reset asserted mid-packet or in EMIT: the partial or pending record is discarded with no output.

## Configuration
- Macro DET_STATS_MAXRUN_EN.
- Defined: run and maxrun tracking is built as described, and o_maxrun carries the longest run.
- Undefined:
  - run/maxrun registers are not built.
  - o_maxrun is tied to 0.
  - The port stays present so the top level is unchanged.

## Structure
- Package det_pkg holds:
  - state enum stats_state_t {IDLE, COUNT, EMIT};
  - default counter width constant DET_CNT_W=8;
  - a saturating-max function sat_inc.
- One sub-module: det_sat_counter.
  - Parameterised CNT_W.
  - Ports: clear/load, inc, value.
  - Saturating.
  - Instantiated for len, ones and run.

## Test plan
- Five-beat packet, inp=1,1,0,1,1, o_ready=1 -> one record: o_len=5, o_ones=4, o_maxrun=2, o_abort=0; o_valid high for exactly 1 cycle; i_ready low during that cycle.
- Single beat with sop=eop=1, inp=1 -> o_len=1, o_ones=1, o_maxrun=1. Next sop accepted 2 cycles after the first beat.
- o_ready=0 for 10 cycles after eop -> o_valid held with the record stable; i_ready=0 throughout; upstream beats on i_valid are ignored. Raising o_ready releases the record within 1 cycle.
- sop, 3 beats, sop again, then 2 beats ending in eop -> record o_len=2 (counted from the second sop), o_abort=1.
- CNT_W=4, 20-beat packet of all 1s -> o_len=15, o_ones=15, o_maxrun=15 (saturated, no wrap).
- Reset asserted asynchronously mid-packet and also during EMIT -> o_valid drops immediately; no record appears. A following clean 2-beat packet produces o_len=2.
